// File: rtl/sync_fiford_arb_if.sv
// Consumer/FIFO-side bundle of the round-robin read-port arbiter.
// The master drives requests and FIFO status; the slave (arbiter) drives grants.
interface sync_fiford_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    logic [NREQ-1:0] req_i;
    logic            rempty_i;
    logic            ren_i;
    logic [DW-1:0]   rdata_i;
    logic            rfifo_o;
    logic [NREQ-1:0] gnt_o;
    logic [NREQ-1:0] vld_o;
    logic [DW-1:0]   rdata_o;
    logic            busy_o;

    modport master (
        output req_i, rempty_i, ren_i, rdata_i,
        input  rfifo_o, gnt_o, vld_o, rdata_o, busy_o
    );

    modport slave (
        input  req_i, rempty_i, ren_i, rdata_i,
        output rfifo_o, gnt_o, vld_o, rdata_o, busy_o
    );
endinterface

// File: rtl/sync_fiford_arb.sv
// Round-robin arbiter sharing one FIFO read port between NREQ consumers,
// granting bursts of up to BURST words with one IDLE bubble between grants.
module sync_fiford_arb #(
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    parameter int DW    = 32,
    parameter int CW    = 8
) (
    input  logic             rclk,
    input  logic             rst_n,
    sync_fiford_arb_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0]     SH_ONE  = 1;
    localparam logic [NREQ-1:0] GNT_ONE = 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, next_state;
    logic [NREQ-1:0] gnt_q, vld_q;
    logic [PW-1:0]   ptr_q, gidx_q, pick_idx;
    logic [CW-1:0]   cnt_q;
    logic [2*NREQ-1:0] rot;
    logic            pick_vld, release_now;
    int              off;

    // Rotate the doubled request vector so bit 0 is the requester after ptr.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rot      = {bus.req_i, bus.req_i} >> ({1'b0, ptr_q} + SH_ONE);
        pick_vld = |bus.req_i;
        off      = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        pick_idx = PW'((int'(ptr_q) + 1 + off) % NREQ);
    end

    always_comb begin
        release_now = (bus.ren_i && (cnt_q == CW'(BURST - 1)))
                   || !bus.req_i[gidx_q]
                   || (bus.rempty_i && !bus.ren_i);
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_vld && !bus.rempty_i) next_state = BUSY;
            BUSY:    if (release_now) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.rfifo_o = (state == BUSY) && bus.req_i[gidx_q];
        bus.busy_o  = (state == BUSY);
        bus.gnt_o   = gnt_q;
        bus.vld_o   = vld_q;
        bus.rdata_o = DW'(bus.rdata_i);
    end

    // Grant, pointer and burst counter; ptr keeps the last winner for rotation.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            vld_q  <= '0;
            gidx_q <= '0;
            ptr_q  <= PW'(NREQ - 1);
            cnt_q  <= '0;
        end else begin
            vld_q <= bus.ren_i ? gnt_q : '0;
            if (state == IDLE) begin
                if (next_state == BUSY) begin
                    gnt_q  <= GNT_ONE << pick_idx;
                    gidx_q <= pick_idx;
                    cnt_q  <= '0;
                end
            end else if (release_now) begin
                gnt_q <= '0;
                ptr_q <= gidx_q;
                cnt_q <= '0;
            end else if (bus.ren_i) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sync_fiford_arb.sv
// Bench for sync_fiford_arb: plays the FIFO read controller, keeps a
// grant/burst model in plain integers and compares every cycle.
module tb_sync_fiford_arb;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int DW    = 32;
    localparam int CW    = 8;

    logic rclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 rclk = ~rclk;

    sync_fiford_arb_if #(.NREQ(NREQ), .DW(DW)) bus();

    sync_fiford_arb #(.NREQ(NREQ), .BURST(BURST), .DW(DW), .CW(CW)) dut (
        .rclk  (rclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] fifo_q[$];

    // Model: granted index (-1 none), words in this burst, last winner, expected vld.
    int              m_g, m_cnt, m_ptr;
    logic [NREQ-1:0] m_vld;

    // Grants and word counts observed on the DUT, checked against hand values.
    int              gl[$], wl[$];
    logic [NREQ-1:0] prev_gnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] gnt_of(input int g);
        logic [NREQ-1:0] one;
        one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int lg(input int i);
        return (i < gl.size()) ? gl[i] : -1;
    endfunction

    function automatic int lw(input int i);
        return (i < wl.size()) ? wl[i] : -1;
    endfunction

    function automatic void model_reset();
        m_g   = -1;
        m_cnt = 0;
        m_ptr = NREQ - 1;
        m_vld = '0;
    endfunction

    // Advance the model over one clock edge using the inputs held before it.
    function automatic void model_edge();
        bit found;
        int k;
        m_vld = bus.ren_i ? gnt_of(m_g) : '0;
        if (m_g < 0) begin
            found = 1'b0;
            if (bus.req_i != '0 && !bus.rempty_i) begin
                for (int i = 1; i <= NREQ; i++) begin
                    k = (m_ptr + i) % NREQ;
                    if (!found && (gnt_of(k) & bus.req_i) != '0) begin
                        found = 1'b1;
                        m_g   = k;
                        m_cnt = 0;
                    end
                end
            end
        end else if ((bus.ren_i && m_cnt == BURST - 1) ||
                     (gnt_of(m_g) & bus.req_i) == '0 ||
                     (bus.rempty_i && !bus.ren_i)) begin
            m_ptr = m_g;
            m_g   = -1;
            m_cnt = 0;
        end else if (bus.ren_i) begin
            m_cnt++;
        end
    endfunction

    // One clock: drive requests/FIFO status, read whenever the arbiter asks.
    task automatic cycle(input logic [NREQ-1:0] r, input int push);
        bus.req_i = r;
        for (int i = 0; i < push; i++) fifo_q.push_back($urandom);
        bus.rempty_i = (fifo_q.size() == 0);
        #1;
        bus.ren_i = bus.rfifo_o && !bus.rempty_i;
        @(posedge rclk);
        #1;
        model_edge();
        if (bus.ren_i) bus.rdata_i = fifo_q.pop_front();
    endtask

    task automatic run(input logic [NREQ-1:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(r, 0);
    endtask

    task automatic hold_reset();
        bus.ren_i = 1'b0;
        bus.req_i = '0;
        model_reset();
        @(posedge rclk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    always @(negedge rclk) begin
        if (!chk_en) begin
            prev_gnt = '0;
        end else begin
            check("gnt",      bus.gnt_o,   gnt_of(m_g));
            check("vld",      bus.vld_o,   m_vld);
            check("rfifo",    bus.rfifo_o, (gnt_of(m_g) & bus.req_i) != '0);
            check("busy",     bus.busy_o,  m_g >= 0);
            check("rdata",    bus.rdata_o, bus.rdata_i);
            check("gnt_1hot", $onehot0(bus.gnt_o), 1);
            check("vld_1hot", $onehot0(bus.vld_o), 1);
            check("ren_wo_rfifo", bus.ren_i && !bus.rfifo_o, 0);
            if (bus.gnt_o != '0 && prev_gnt == '0) begin
                gl.push_back(idx_of(bus.gnt_o));
                wl.push_back(0);
            end
            if (bus.vld_o != '0 && wl.size() > 0) wl[wl.size()-1]++;
            prev_gnt = bus.gnt_o;
        end
    end

    initial begin
        logic [NREQ-1:0] r;
        bit reached;

        bus.req_i    = '0;
        bus.rempty_i = 1'b1;
        bus.ren_i    = 1'b0;
        bus.rdata_i  = '0;
        model_reset();
        #1;
        check("rst_gnt",   bus.gnt_o,   0);
        check("rst_vld",   bus.vld_o,   0);
        check("rst_busy",  bus.busy_o,  0);
        check("rst_rfifo", bus.rfifo_o, 0);
        @(posedge rclk);
        hold_reset();

        // 1: single requester, 6 words -> bursts of 4 then 2.
        gl.delete(); wl.delete();
        cycle(4'b0001, 6);
        run(4'b0001, 14);
        check("t1_n",  gl.size(), 2);
        check("t1_g0", lg(0), 0);
        check("t1_w0", lw(0), 4);
        check("t1_g1", lg(1), 0);
        check("t1_w1", lw(1), 2);

        // 2: all requesting after reset -> 0,1,2,3 with 4 words each.
        rst_n  = 1'b0;
        chk_en = 1'b0;
        hold_reset();
        gl.delete(); wl.delete();
        cycle(4'b1111, 16);
        run(4'b1111, 28);
        check("t2_n", gl.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_g", lg(i), i);
            check("t2_w", lw(i), 4);
        end

        // 3: ptr=3, requests 0 and 3 -> wrap to 0.
        gl.delete(); wl.delete();
        cycle(4'b1001, 4);
        run(4'b1001, 9);
        check("t3_n",  gl.size(), 1);
        check("t3_g0", lg(0), 0);
        check("t3_w0", lw(0), 4);

        // 4: grant 2, withdraw after 2 words -> next grant to 3.
        gl.delete(); wl.delete();
        cycle(4'b0100, 8);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_g == 2 && m_cnt == 2) reached = 1'b1;
            else cycle(4'b0100, 0);
        end
        check("t4_wait", reached, 1);
        run(4'b1000, 16);
        check("t4_n",  gl.size(), 3);
        check("t4_g0", lg(0), 2);
        check("t4_w0", lw(0), 2);
        check("t4_g1", lg(1), 3);
        check("t4_w1", lw(1), 4);
        check("t4_w2", lw(2), 2);

        // 5: empty FIFO holds IDLE; one word -> grant 0, one read.
        gl.delete(); wl.delete();
        run(4'b1111, 5);
        check("t5_busy",  bus.busy_o,  0);
        check("t5_rfifo", bus.rfifo_o, 0);
        cycle(4'b1111, 1);
        run(4'b1111, 6);
        check("t5_n",  gl.size(), 1);
        check("t5_g0", lg(0), 0);
        check("t5_w0", lw(0), 1);

        // 6: asynchronous reset mid-burst, then requester 0 first.
        cycle(4'b1111, 8);
        run(4'b1111, 3);
        chk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_gnt",   bus.gnt_o,   0);
        check("t6_vld",   bus.vld_o,   0);
        check("t6_rfifo", bus.rfifo_o, 0);
        check("t6_busy",  bus.busy_o,  0);
        hold_reset();
        gl.delete(); wl.delete();
        run(4'b1111, 12);
        check("t6_g0", lg(0), 0);
        check("t6_w0", lw(0), 4);
        check("t6_g1", lg(1), 1);

        // Random traffic against the model.
        r = 4'($urandom_range(0, 15));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(r, (fifo_q.size() < 32 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
